lcd_ctrl: RTL and testbench



---
 rtl/lcd_pkg.sv | 28 ++
 rtl/lcd_ctrl_if.sv | 10 +
 rtl/lcd_timer.sv | 28 ++
 rtl/lcd_ctrl.sv | 138 +++++++++++++
 tb/tb_lcd_ctrl.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared types, opcodes and helpers for the character-LCD controller.
package lcd_pkg;

  typedef enum logic [2:0] {
    StPowerOn,
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StWait
  } lcd_state_e;

  localparam logic [7:0] LCD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_HOME  = 8'h02;

  // Power-on init: function set, display on, clear, entry mode (index 0 first).
  localparam logic [3:0][7:0] INIT_CMDS = {8'h06, 8'h01, 8'h0C, 8'h38};

  // Clear and home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(logic rs, logic [7:0] data);
    return !rs && ((data == LCD_CLEAR) || (data[7:1] == LCD_HOME[7:1]));
  endfunction

  function automatic int unsigned max_u(int unsigned a, int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_ctrl_if.sv
// Command handshake between the core's LCD port and the controller.
interface lcd_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rs;
  logic [7:0] cmd_data;

  modport master (output cmd_valid, output cmd_rs, output cmd_data, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_rs, input cmd_data, output cmd_ready);
endinterface

// File: rtl/lcd_timer.sv
// Loadable down-counter shared by every timed phase; done while the count is zero.
module lcd_timer #(
  parameter int unsigned       Width    = 8,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [Width-1:0] load_val_i,
  output logic             done_o
);

  logic [Width-1:0] cnt_q;

  // Load takes priority; otherwise count down and park at zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= ResetVal;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - Width'(1);
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_ctrl.sv
// Write-only HD44780 controller: power-on init, then one timed bus cycle per request.
module lcd_ctrl
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERON    = 20000,
  parameter int unsigned T_SETUP      = 2,
  parameter int unsigned T_PULSE      = 12,
  parameter int unsigned T_HOLD       = 2,
  parameter int unsigned T_WAIT       = 2000,
  parameter int unsigned T_CLEAR_WAIT = 80000
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  lcd_ctrl_if.slave  cmd,
  output logic       init_done_o,
  output logic       lcd_on_o,
  output logic       lcd_en_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic [7:0] lcd_data_o
);

  localparam int unsigned MaxT = max_u(max_u(max_u(T_POWERON, T_SETUP), max_u(T_PULSE, T_HOLD)),
                                       max_u(T_WAIT, T_CLEAR_WAIT));
  localparam int unsigned CntW = $clog2(MaxT) + 1;

  lcd_state_e      state_q;
  logic [1:0]      idx_q;
  logic            init_done_q, lcd_on_q, en_q, rs_q, ready_q;
  logic [7:0]      data_q;
  logic            tmr_load, tmr_done;
  logic [CntW-1:0] tmr_val;

  // Reload the timer with (phase length - 1) on every transition into a timed phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      StPowerOn: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = CntW'(T_SETUP - 1);
      end
      StIdle: if (cmd.cmd_valid && ready_q) begin
        tmr_load = 1'b1;
        tmr_val  = CntW'(T_SETUP - 1);
      end
      StSetup: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = CntW'(T_PULSE - 1);
      end
      StPulse: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = CntW'(T_HOLD - 1);
      end
      StHold: if (tmr_done) begin
        tmr_load = 1'b1;
        tmr_val  = is_long_cmd(rs_q, data_q) ? CntW'(T_CLEAR_WAIT - 1) : CntW'(T_WAIT - 1);
      end
      StWait: if (tmr_done && !init_done_q && (idx_q != 2'd3)) begin
        tmr_load = 1'b1;
        tmr_val  = CntW'(T_SETUP - 1);
      end
      default: ;
    endcase
  end

  lcd_timer #(
    .Width    (CntW),
    .ResetVal (CntW'(T_POWERON - 1))
  ) u_timer (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Sequencer with registered bus and handshake outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StPowerOn;
      idx_q       <= 2'd0;
      init_done_q <= 1'b0;
      lcd_on_q    <= 1'b0;
      en_q        <= 1'b0;
      rs_q        <= 1'b0;
      data_q      <= 8'h00;
      ready_q     <= 1'b0;
    end else begin
      lcd_on_q <= 1'b1;
      unique case (state_q)
        StPowerOn: if (tmr_done) begin
          rs_q    <= 1'b0;
          data_q  <= INIT_CMDS[idx_q];
          state_q <= StSetup;
        end
        StIdle: if (cmd.cmd_valid && ready_q) begin
          rs_q    <= cmd.cmd_rs;
          data_q  <= cmd.cmd_data;
          ready_q <= 1'b0;
          state_q <= StSetup;
        end
        StSetup: if (tmr_done) begin
          en_q    <= 1'b1;
          state_q <= StPulse;
        end
        StPulse: if (tmr_done) begin
          en_q    <= 1'b0;
          state_q <= StHold;
        end
        StHold: if (tmr_done) begin
          state_q <= StWait;
        end
        StWait: if (tmr_done) begin
          if (!init_done_q && (idx_q != 2'd3)) begin
            idx_q   <= idx_q + 2'd1;
            data_q  <= INIT_CMDS[idx_q + 2'd1];
            state_q <= StSetup;
          end else begin
            init_done_q <= 1'b1;
            ready_q     <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StPowerOn;
      endcase
    end
  end

  assign cmd.cmd_ready = ready_q;
  assign init_done_o   = init_done_q;
  assign lcd_on_o      = lcd_on_q;
  assign lcd_en_o      = en_q;
  assign lcd_rs_o      = rs_q;
  assign lcd_rw_o      = 1'b0;
  assign lcd_data_o    = data_q;

endmodule

// File: tb/tb_lcd_ctrl.sv
// Directed bench for lcd_ctrl with a pulse scoreboard.
module tb_lcd_ctrl;

  localparam int unsigned T_POWERON    = 100;
  localparam int unsigned T_SETUP      = 2;
  localparam int unsigned T_PULSE      = 4;
  localparam int unsigned T_HOLD       = 2;
  localparam int unsigned T_WAIT       = 10;
  localparam int unsigned T_CLEAR_WAIT = 50;
  localparam int INIT_CYC  = 212;
  localparam int SHORT_CYC = 18;
  localparam int LONG_CYC  = 58;

  logic       clk_i  = 1'b0;
  logic       rst_ni = 1'b0;
  logic       init_done, lcd_on, lcd_en, lcd_rs, lcd_rw;
  logic [7:0] lcd_data;

  int checks   = 0;
  int failures = 0;

  logic [8:0] exp_q[$];

  always #5 clk_i = ~clk_i;

  lcd_ctrl_if bus ();

  lcd_ctrl #(
    .T_POWERON    (T_POWERON),
    .T_SETUP      (T_SETUP),
    .T_PULSE      (T_PULSE),
    .T_HOLD       (T_HOLD),
    .T_WAIT       (T_WAIT),
    .T_CLEAR_WAIT (T_CLEAR_WAIT)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .cmd         (bus),
    .init_done_o (init_done),
    .lcd_on_o    (lcd_on),
    .lcd_en_o    (lcd_en),
    .lcd_rs_o    (lcd_rs),
    .lcd_rw_o    (lcd_rw),
    .lcd_data_o  (lcd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: each completed EN pulse pops one expected {rs,data}.
  logic       en_prev = 1'b0;
  int         width   = 0;
  logic [8:0] rise_val;
  always @(negedge clk_i) begin
    check("rw_zero", 32'(lcd_rw), 32'd0);
    if (!rst_ni) begin
      en_prev = 1'b0;
      width   = 0;
    end else begin
      if (lcd_en) begin
        if (!en_prev) begin
          rise_val = {lcd_rs, lcd_data};
          width    = 1;
        end else begin
          width++;
          check("bus_stable_in_pulse", 32'({lcd_rs, lcd_data}), 32'(rise_val));
        end
      end else if (en_prev) begin
        if (exp_q.size() == 0) begin
          check("pulse_expected", 32'd0, 32'd1);
        end else begin
          check("pulse_rs_data", 32'(rise_val), 32'(exp_q.pop_front()));
        end
        check("pulse_width", 32'(width), 32'(T_PULSE));
      end
      en_prev = lcd_en;
    end
  end

  // Release reset and time the init sequence up to init_done.
  task automatic run_init();
    int k;
    exp_q.push_back({1'b0, 8'h38});
    exp_q.push_back({1'b0, 8'h0C});
    exp_q.push_back({1'b0, 8'h01});
    exp_q.push_back({1'b0, 8'h06});
    @(negedge clk_i);
    rst_ni = 1'b1;
    k = 0;
    while (k < 1000) begin
      @(posedge clk_i);
      #1;
      k++;
      if (k == 1) check("lcd_on_after_release", 32'(lcd_on), 32'd1);
      check("ready_tracks_init_done", 32'(bus.cmd_ready), 32'(init_done));
      if (init_done) break;
    end
    check("init_cycles", 32'(k), 32'(INIT_CYC));
    check("init_pulses_consumed", 32'(exp_q.size()), 32'd0);
  endtask

  // Time one transfer from its accept edge; optionally change data mid-transfer.
  task automatic time_cmd(input string tag, input int exp_ready, input bit change_mid,
                          input logic [7:0] bus_val);
    int k, rise, fall;
    k = 0; rise = -1; fall = -1;
    while (k < 300) begin
      @(posedge clk_i);
      #1;
      k++;
      if (lcd_en && rise < 0) rise = k;
      if (!lcd_en && rise >= 0 && fall < 0) fall = k;
      if (change_mid) begin
        check({tag, "_bus_held"}, 32'(lcd_data), 32'(bus_val));
        if (k == 3) begin
          bus.cmd_data = 8'h42;
          exp_q.push_back({1'b1, 8'h42});
        end
      end
      if (bus.cmd_ready) break;
    end
    check({tag, "_en_rise"}, 32'(rise), 32'(T_SETUP));
    check({tag, "_en_fall"}, 32'(fall), 32'(T_SETUP + T_PULSE));
    check({tag, "_ready_cycles"}, 32'(k), 32'(exp_ready));
  endtask

  task automatic send(input string tag, input logic rs, input logic [7:0] d,
                      input int exp_ready, input bit keep_valid);
    @(negedge clk_i);
    check({tag, "_ready_before"}, 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = rs;
    bus.cmd_data  = d;
    exp_q.push_back({rs, d});
    @(posedge clk_i);
    #1;
    if (!keep_valid) bus.cmd_valid = 1'b0;
    check({tag, "_ready_drop"}, 32'(bus.cmd_ready), 32'd0);
    time_cmd(tag, exp_ready, keep_valid, d);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_rs    = 1'b0;
    bus.cmd_data  = 8'h00;
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_lcd_on", 32'(lcd_on), 32'd0);
    check("rst_en", 32'(lcd_en), 32'd0);
    check("rst_ready", 32'(bus.cmd_ready), 32'd0);
    check("rst_init_done", 32'(init_done), 32'd0);
    check("rst_bus", 32'({lcd_rs, lcd_data}), 32'd0);

    run_init();

    send("data_41", 1'b1, 8'h41, SHORT_CYC, 1'b0);
    send("clear", 1'b0, 8'h01, LONG_CYC, 1'b0);
    send("data_01", 1'b1, 8'h01, SHORT_CYC, 1'b0);
    send("home_03", 1'b0, 8'h03, LONG_CYC, 1'b0);

    // Held request with data changing mid-transfer; second accept when ready returns.
    send("hold_41", 1'b1, 8'h41, SHORT_CYC, 1'b1);
    @(posedge clk_i);
    #1;
    bus.cmd_valid = 1'b0;
    check("accept_on_ready", 32'(bus.cmd_ready), 32'd0);
    check("second_latched", 32'({lcd_rs, lcd_data}), 32'({1'b1, 8'h42}));
    time_cmd("second_42", SHORT_CYC, 1'b0, 8'h42);

    // Reset during PULSE aborts the transfer and reruns init.
    @(negedge clk_i);
    bus.cmd_valid = 1'b1;
    bus.cmd_rs    = 1'b1;
    bus.cmd_data  = 8'h33;
    exp_q.push_back({1'b1, 8'h33});
    @(posedge clk_i);
    #1;
    bus.cmd_valid = 1'b0;
    repeat (3) @(posedge clk_i);
    #1;
    check("en_before_abort", 32'(lcd_en), 32'd1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("abort_en", 32'(lcd_en), 32'd0);
    check("abort_ready", 32'(bus.cmd_ready), 32'd0);
    check("abort_init_done", 32'(init_done), 32'd0);
    check("abort_lcd_on", 32'(lcd_on), 32'd0);
    check("abort_bus", 32'({lcd_rs, lcd_data}), 32'd0);
    void'(exp_q.pop_front());
    repeat (3) @(posedge clk_i);
    run_init();

    send("post_reset_41", 1'b1, 8'h41, SHORT_CYC, 1'b0);
    repeat (5) @(posedge clk_i);
    #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
